// File: rtl/intra_net_pkg.sv
// Shared types and constants for the intra-network transpose job scheduler.
package intra_net_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DIM = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam int COL_DIM_DEF    = 16;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int TAG_WIDTH_DEF  = 2;
  localparam int JOB_W_DEF      = 2 * $clog2(COL_DIM_DEF) + 2 * ADDR_WIDTH_DEF + TAG_WIDTH_DEF;

  // Job record layout is {A, B, O_base, A_base, tag}.
  function automatic int job_w(input int dw, input int aw, input int tw);
    return 2 * dw + 2 * aw + tw;
  endfunction

endpackage

// File: rtl/intra_net_job_fifo.sv
// Generic synchronous FIFO with flush; storage is not reset, only pointers and count.
module intra_net_job_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/intra_net_sched.sv
// Job scheduler for the intra-network transpose engine: queues host jobs,
// issues them one at a time, enforces a run timeout and reports completion.
module intra_net_sched
  import intra_net_pkg::*;
#(
  parameter int COL_DIM     = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int QDEPTH      = 4,
  parameter int TAG_WIDTH   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [$clog2(COL_DIM)-1:0]  job_A,
  input  logic [$clog2(COL_DIM)-1:0]  job_B,
  input  logic [ADDR_WIDTH-1:0]       job_O_base,
  input  logic [ADDR_WIDTH-1:0]       job_A_base,
  input  logic [TAG_WIDTH-1:0]        job_tag,
  input  logic                        flush,
  output logic [$clog2(COL_DIM)-1:0]  A,
  output logic [$clog2(COL_DIM)-1:0]  B,
  output logic [ADDR_WIDTH-1:0]       O_base_addr,
  output logic [ADDR_WIDTH-1:0]       A_base_addr,
  output logic                        sig_start,
  input  logic                        sig_end,
  output logic                        core_clr,
  output logic                        done,
  output logic [TAG_WIDTH-1:0]        done_tag,
  output logic [1:0]                  done_err,
  output logic                        busy,
  output logic [$clog2(QDEPTH):0]     pending
);

  localparam int DW    = $clog2(COL_DIM);
  localparam int JOB_W = job_w(DW, ADDR_WIDTH, TAG_WIDTH);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [JOB_W-1:0]   job_din;
  logic [JOB_W-1:0]   job_dout;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [1:0]         err_q;
  logic [1:0]         err_nxt;
  logic [CNT_W-1:0]   run_cnt;

  assign job_ready = !fifo_full;
  assign fifo_push = job_valid && !fifo_full;
  assign job_din   = {job_A, job_B, job_O_base, job_A_base, job_tag};

  intra_net_job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (QDEPTH)
  ) u_job_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (job_din),
    .dout  (job_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    fifo_pop  = 1'b0;
    sig_start = 1'b0;
    done      = 1'b0;
    core_clr  = 1'b0;
    done_tag  = '0;
    done_err  = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (A == '0 || B == '0) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_DIM;
        end else begin
          state_nxt = S_RUN;
          err_nxt   = ERR_OK;
        end
      end
      S_RUN: begin
        sig_start = 1'b1;
        // Completion beats the timeout when both land in the same cycle.
        if (sig_end) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_OK;
        end else if (run_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = S_DONE;
          err_nxt   = ERR_TMO;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        done_tag  = tag_q;
        done_err  = err_q;
        core_clr  = (err_q == ERR_TMO);
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (!sig_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config registers hold the issued job for the whole LOAD..GAP window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A           <= '0;
      B           <= '0;
      O_base_addr <= '0;
      A_base_addr <= '0;
      tag_q       <= '0;
      err_q       <= ERR_OK;
      run_cnt     <= '0;
    end else begin
      if (fifo_pop) {A, B, O_base_addr, A_base_addr, tag_q} <= job_dout;
      err_q   <= err_nxt;
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_intra_net_sched.sv
// Directed bench for intra_net_sched: table-driven queue sequence plus hand-written corner cases.
module tb_intra_net_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic       job_ready;
  logic [3:0] job_A, job_B;
  logic [9:0] job_O_base, job_A_base;
  logic [1:0] job_tag;
  logic       flush;
  logic [3:0] A, B;
  logic [9:0] O_base_addr, A_base_addr;
  logic       sig_start, sig_end, core_clr, done, busy;
  logic [1:0] done_tag, done_err;
  logic [2:0] pending;

  logic       t_valid;
  logic       t_ready, t_start, t_clr, t_done, t_busy;
  logic [3:0] t_A, t_B;
  logic [9:0] t_O, t_Ab;
  logic [1:0] t_dtag, t_derr;
  logic [2:0] t_pend;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intra_net_sched #(.COL_DIM(16), .ADDR_WIDTH(10), .QDEPTH(4), .TAG_WIDTH(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_A(job_A), .job_B(job_B), .job_O_base(job_O_base), .job_A_base(job_A_base),
    .job_tag(job_tag), .flush(flush), .A(A), .B(B), .O_base_addr(O_base_addr),
    .A_base_addr(A_base_addr), .sig_start(sig_start), .sig_end(sig_end),
    .core_clr(core_clr), .done(done), .done_tag(done_tag), .done_err(done_err),
    .busy(busy), .pending(pending)
  );

  intra_net_sched #(.COL_DIM(16), .ADDR_WIDTH(10), .QDEPTH(4), .TAG_WIDTH(2), .TIMEOUT_CYC(16)) dut_tmo (
    .clk(clk), .reset(reset), .job_valid(t_valid), .job_ready(t_ready),
    .job_A(4'd3), .job_B(4'd5), .job_O_base(10'd7), .job_A_base(10'd9),
    .job_tag(2'd3), .flush(1'b0), .A(t_A), .B(t_B), .O_base_addr(t_O),
    .A_base_addr(t_Ab), .sig_start(t_start), .sig_end(1'b0),
    .core_clr(t_clr), .done(t_done), .done_tag(t_dtag), .done_err(t_derr),
    .busy(t_busy), .pending(t_pend)
  );

  typedef struct {
    logic       v;
    logic [1:0] tag;
    logic       se;
    logic       rdy;
    logic [2:0] pend;
    logic       st;
    logic       bsy;
    logic       dn;
    logic [1:0] dtag;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int v, tag, se, rdy, pend, st, bsy, dn, dtag);
    vec_t r;
    r.v = 1'(v); r.tag = 2'(tag); r.se = 1'(se); r.rdy = 1'(rdy); r.pend = 3'(pend);
    r.st = 1'(st); r.bsy = 1'(bsy); r.dn = 1'(dn); r.dtag = 2'(dtag);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_job(input int a, input int b, input int o, input int ab, input int tag);
    job_valid = 1'b1;
    job_A = 4'(a); job_B = 4'(b); job_O_base = 10'(o); job_A_base = 10'(ab); job_tag = 2'(tag);
  endtask

  initial begin
    int hi;
    logic seen;
    reset = 1'b0; job_valid = 1'b0; job_A = '0; job_B = '0; job_O_base = '0;
    job_A_base = '0; job_tag = '0; flush = 1'b0; sig_end = 1'b0; t_valid = 1'b0;
    tick; tick;

    // Reset state
    chk("rst_ready", 32'(job_ready), 1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_start", 32'(sig_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_A", 32'(A), 0);
    chk("rst_obase", 32'(O_base_addr), 0);
    chk("rst_clr", 32'(core_clr), 0);
    chk("rst_t_ready", 32'(t_ready), 1);
    chk("rst_t_pend", 32'(t_pend), 0);
    reset = 1'b1;
    tick;

    // Single job
    set_job(10, 8, 100, 200, 1);
    tick;
    job_valid = 1'b0;
    chk("sj_pending", 32'(pending), 1);
    chk("sj_idle_start", 32'(sig_start), 0);
    tick;
    chk("sj_A", 32'(A), 10);
    chk("sj_B", 32'(B), 8);
    chk("sj_obase", 32'(O_base_addr), 100);
    chk("sj_abase", 32'(A_base_addr), 200);
    chk("sj_load_start", 32'(sig_start), 0);
    chk("sj_load_busy", 32'(busy), 1);
    tick;
    chk("sj_run_start", 32'(sig_start), 1);
    for (int i = 1; i < 20; i++) tick;
    chk("sj_run_hold", 32'(sig_start), 1);
    chk("sj_run_A", 32'(A), 10);
    sig_end = 1'b1;
    tick;
    chk("sj_done", 32'(done), 1);
    chk("sj_done_tag", 32'(done_tag), 1);
    chk("sj_done_err", 32'(done_err), 0);
    chk("sj_done_start", 32'(sig_start), 0);
    sig_end = 1'b0;
    tick;
    chk("sj_gap_done", 32'(done), 0);
    tick;
    chk("sj_idle_busy", 32'(busy), 0);

    // Timeout on the 16-cycle instance
    t_valid = 1'b1;
    tick;
    t_valid = 1'b0;
    hi = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick;
      if (t_start) begin
        hi++;
        if (hi == 1) begin
          chk("tmo_A", 32'(t_A), 3);
          chk("tmo_B", 32'(t_B), 5);
          chk("tmo_obase", 32'(t_O), 7);
          chk("tmo_abase", 32'(t_Ab), 9);
        end
      end
      if (t_done) begin
        seen = 1'b1;
        chk("tmo_clr", 32'(t_clr), 1);
        chk("tmo_err", 32'(t_derr), 2);
        chk("tmo_tag", 32'(t_dtag), 3);
      end
    end
    chk("tmo_done_seen", 32'(seen), 1);
    chk("tmo_start_cycles", 32'(hi), 16);
    tick;
    chk("tmo_clr_drop", 32'(t_clr), 0);
    chk("tmo_gap_busy", 32'(t_busy), 1);

    // Queue full: a blocker job is running while five jobs are offered
    set_job(1, 1, 0, 0, 3);
    tick;
    job_valid = 1'b0;
    tick; tick;
    chk("qf_blocker_run", 32'(sig_start), 1);
    //          v tag se | rdy pend st bsy dn dtag
    vq.push_back(mk(1, 0, 0,  1, 1, 1, 1, 0, 0));
    vq.push_back(mk(1, 1, 0,  1, 2, 1, 1, 0, 0));
    vq.push_back(mk(1, 2, 0,  1, 3, 1, 1, 0, 0));
    vq.push_back(mk(1, 3, 0,  0, 4, 1, 1, 0, 0));
    vq.push_back(mk(1, 2, 0,  0, 4, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 1,  0, 4, 0, 1, 1, 3));
    vq.push_back(mk(0, 0, 0,  0, 4, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  0, 4, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 3, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 1,  1, 3, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,  1, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 2, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 2, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 1,  1, 2, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,  1, 2, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 1,  1, 1, 0, 1, 1, 2));
    vq.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 0, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 1,  1, 0, 0, 1, 1, 3));
    vq.push_back(mk(0, 0, 0,  1, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0));
    job_A = 4'd2; job_B = 4'd3; job_O_base = 10'd11; job_A_base = 10'd22;
    for (int i = 0; i < vq.size(); i++) begin
      job_valid = vq[i].v;
      job_tag   = vq[i].tag;
      sig_end   = vq[i].se;
      tick;
      chk($sformatf("qf%0d_ready", i), 32'(job_ready), 32'(vq[i].rdy));
      chk($sformatf("qf%0d_pending", i), 32'(pending), 32'(vq[i].pend));
      chk($sformatf("qf%0d_start", i), 32'(sig_start), 32'(vq[i].st));
      chk($sformatf("qf%0d_busy", i), 32'(busy), 32'(vq[i].bsy));
      chk($sformatf("qf%0d_done", i), 32'(done), 32'(vq[i].dn));
      chk($sformatf("qf%0d_dtag", i), 32'(done_tag), 32'(vq[i].dtag));
      chk($sformatf("qf%0d_derr", i), 32'(done_err), 0);
    end
    job_valid = 1'b0;
    sig_end = 1'b0;

    // Zero dimension, followed by a normal job
    set_job(0, 8, 1, 2, 2);
    tick;
    set_job(5, 5, 3, 4, 1);
    tick;
    job_valid = 1'b0;
    chk("zd_load_start", 32'(sig_start), 0);
    tick;
    chk("zd_done", 32'(done), 1);
    chk("zd_err", 32'(done_err), 1);
    chk("zd_tag", 32'(done_tag), 2);
    chk("zd_start", 32'(sig_start), 0);
    chk("zd_clr", 32'(core_clr), 0);
    tick; tick; tick; tick;
    chk("zd_next_start", 32'(sig_start), 1);
    chk("zd_next_A", 32'(A), 5);
    sig_end = 1'b1;
    tick;
    chk("zd_next_done", 32'(done), 1);
    chk("zd_next_tag", 32'(done_tag), 1);
    chk("zd_next_err", 32'(done_err), 0);
    sig_end = 1'b0;
    tick; tick;

    // Sticky sig_end holds the FSM in GAP
    set_job(4, 4, 5, 6, 0);
    tick;
    set_job(7, 6, 8, 9, 1);
    tick;
    job_valid = 1'b0;
    tick;
    chk("st_run", 32'(sig_start), 1);
    sig_end = 1'b1;
    tick;
    chk("st_done_tag0", 32'(done_tag), 0);
    chk("st_done", 32'(done), 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("st_gap%0d_busy", i), 32'(busy), 1);
      chk($sformatf("st_gap%0d_start", i), 32'(sig_start), 0);
      chk($sformatf("st_gap%0d_pend", i), 32'(pending), 1);
    end
    sig_end = 1'b0;
    tick;
    chk("st_idle_busy", 32'(busy), 0);
    chk("st_idle_pend", 32'(pending), 1);
    tick;
    chk("st_load_pend", 32'(pending), 0);
    chk("st_load_A", 32'(A), 7);
    chk("st_load_start", 32'(sig_start), 0);
    tick;
    chk("st_run2", 32'(sig_start), 1);
    sig_end = 1'b1;
    tick;
    chk("st_done_tag1", 32'(done_tag), 1);
    sig_end = 1'b0;
    tick; tick;

    // Flush with one running and three queued, including a discarded push
    for (int i = 0; i < 4; i++) begin
      set_job(2, 2, i, i, i);
      tick;
    end
    chk("fl_pending", 32'(pending), 3);
    chk("fl_running", 32'(sig_start), 1);
    set_job(3, 3, 0, 0, 2);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    job_valid = 1'b0;
    chk("fl_pending0", 32'(pending), 0);
    chk("fl_ready", 32'(job_ready), 1);
    chk("fl_still_run", 32'(sig_start), 1);
    sig_end = 1'b1;
    tick;
    chk("fl_done", 32'(done), 1);
    chk("fl_done_tag", 32'(done_tag), 0);
    sig_end = 1'b0;
    tick; tick;
    chk("fl_idle_busy", 32'(busy), 0);
    tick;
    chk("fl_no_more", 32'(busy), 0);

    // Asynchronous reset in the middle of RUN
    set_job(9, 9, 1, 1, 1);
    tick;
    job_valid = 1'b0;
    tick; tick; tick;
    chk("rr_run", 32'(sig_start), 1);
    reset = 1'b0;
    #1;
    chk("rr_start", 32'(sig_start), 0);
    chk("rr_ready", 32'(job_ready), 1);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_A", 32'(A), 0);
    tick;
    chk("rr_no_done", 32'(done), 0);
    reset = 1'b1;
    tick;
    chk("rr_after_done", 32'(done), 0);
    chk("rr_after_busy", 32'(busy), 0);
    chk("rr_after_pend", 32'(pending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
